init_stream_sink: RTL and testbench

Receiving end of the memory-initialization stream. The init generator emits a free-running, cyclic (address, data) sequence per storage array (BTB, BHT, register file); one `init_stream_sink` instance per array locks onto that sequence, writes exactly one full pass of entries 0..DEPTH-1 into the array's write port, then hands the port to the core. Core writes are stalled until the array is fully initialized. Sequence breaks are detected and force a resync.

---
 rtl/init_stream_sink.sv | 167 ++++++++++++++++
 tb/tb_init_stream_sink.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/init_stream_sink.sv
// init_stream_sink
// Locks onto a cyclic (address, data) initialization stream, writes exactly
// one full pass of entries 0..DEPTH-1 into an array write port, then hands
// the port over to the core. Core writes are stalled (and dropped) until the
// array is fully initialized. Sequence breaks set a sticky error and force a
// resync at address 0.
module init_stream_sink #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 40
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          init_valid_i,
  input  logic [AW-1:0] init_addr_i,
  input  logic [DW-1:0] init_data_i,
  output logic          init_ready_o,
  input  logic          restart_i,
  input  logic          core_we_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [DW-1:0] core_data_i,
  output logic          core_stall_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_data_o,
  output logic          init_done_o,
  output logic          init_err_o,
  output logic [AW:0]   init_count_o
);

  localparam logic [1:0]    ST_WAIT_ZERO = 2'd0;
  localparam logic [1:0]    ST_FILL      = 2'd1;
  localparam logic [1:0]    ST_DONE      = 2'd2;

  localparam logic [AW-1:0] ZERO_ADDR    = {AW{1'b0}};
  localparam logic [AW-1:0] LAST_ADDR    = AW'(DEPTH - 1);
  localparam logic [AW:0]   ZERO_COUNT   = {(AW+1){1'b0}};
  localparam logic [AW:0]   ONE_COUNT    = (AW+1)'(1);
  localparam logic [AW:0]   FULL_COUNT   = (AW+1)'(DEPTH);
  // After the entry-0 beat a single-entry array is already complete.
  localparam logic [1:0]    ST_AFTER_ZERO = (DEPTH == 1) ? ST_DONE : ST_FILL;

  logic [1:0]    state_r;
  logic [AW:0]   count_r;
  logic          mem_we_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_data_r;
  logic          done_r;
  logic          err_r;

  logic [1:0]    state_s;
  logic [AW:0]   count_s;
  logic          err_s;
  logic          done_s;
  logic          we_s;
  logic [AW-1:0] waddr_s;
  logic [DW-1:0] wdata_s;
  logic [AW-1:0] exp_addr_s;

  assign exp_addr_s   = count_r[AW-1:0];
  assign init_ready_o = (state_r != ST_DONE);
  assign core_stall_o = (state_r != ST_DONE);
  assign mem_we_o     = mem_we_r;
  assign mem_addr_o   = mem_addr_r;
  assign mem_data_o   = mem_data_r;
  assign init_done_o  = done_r;
  assign init_err_o   = err_r;
  assign init_count_o = count_r;

  // Next-state, count, error and write-port selection; restart wins over all.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    err_s   = err_r;
    we_s    = 1'b0;
    waddr_s = mem_addr_r;
    wdata_s = mem_data_r;
    if (restart_i) begin
      state_s = ST_WAIT_ZERO;
      count_s = ZERO_COUNT;
      err_s   = 1'b0;
    end else begin
      case (state_r)
        ST_WAIT_ZERO: begin
          if (init_valid_i && (init_addr_i == ZERO_ADDR)) begin
            we_s    = 1'b1;
            waddr_s = init_addr_i;
            wdata_s = init_data_i;
            count_s = ONE_COUNT;
            state_s = ST_AFTER_ZERO;
          end else begin
            state_s = ST_WAIT_ZERO;
          end
        end
        ST_FILL: begin
          if (!init_valid_i) begin
            state_s = ST_FILL;
          end else if (init_addr_i == exp_addr_s) begin
            we_s    = 1'b1;
            waddr_s = init_addr_i;
            wdata_s = init_data_i;
            if (init_addr_i == LAST_ADDR) begin
              count_s = FULL_COUNT;
              state_s = ST_DONE;
            end else begin
              count_s = count_r + ONE_COUNT;
            end
          end else if (init_addr_i == ZERO_ADDR) begin
            // Stream restarted under us: take entry 0 and refill from there.
            we_s    = 1'b1;
            waddr_s = init_addr_i;
            wdata_s = init_data_i;
            err_s   = 1'b1;
            count_s = ONE_COUNT;
          end else begin
            err_s   = 1'b1;
            count_s = ZERO_COUNT;
            state_s = ST_WAIT_ZERO;
          end
        end
        ST_DONE: begin
          if (core_we_i) begin
            we_s    = 1'b1;
            waddr_s = core_addr_i;
            wdata_s = core_data_i;
          end else begin
            we_s    = 1'b0;
          end
        end
        default: begin
          state_s = ST_WAIT_ZERO;
          count_s = ZERO_COUNT;
        end
      endcase
    end
    done_s = (state_s == ST_DONE);
  end

  // State, count and status registers.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_WAIT_ZERO;
      count_r <= ZERO_COUNT;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

  // Registered array write port; address/data hold when no write is issued.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_we_r   <= 1'b0;
      mem_addr_r <= ZERO_ADDR;
      mem_data_r <= {DW{1'b0}};
    end else begin
      mem_we_r   <= we_s;
      mem_addr_r <= waddr_s;
      mem_data_r <= wdata_s;
    end
  end

endmodule

// File: tb/tb_init_stream_sink.sv
// Directed bench for init_stream_sink: a vector table for single-cycle
// behaviour plus hand-written full-pass, restart, reset and DEPTH=1 sequences.
module tb_init_stream_sink;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int DW    = 40;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          init_valid_i;
  logic [AW-1:0] init_addr_i;
  logic [DW-1:0] init_data_i;
  logic          init_ready_o;
  logic          restart_i;
  logic          core_we_i;
  logic [AW-1:0] core_addr_i;
  logic [DW-1:0] core_data_i;
  logic          core_stall_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          init_done_o;
  logic          init_err_o;
  logic [AW:0]   init_count_o;

  // single-entry instance
  logic          s_valid;
  logic [0:0]    s_addr;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          s_restart;
  logic          s_core_we;
  logic [0:0]    s_core_addr;
  logic [DW-1:0] s_core_data;
  logic          s_stall;
  logic          s_we;
  logic [0:0]    s_maddr;
  logic [DW-1:0] s_mdata;
  logic          s_done;
  logic          s_err;
  logic [1:0]    s_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  init_stream_sink #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_ni(rst_ni),
    .init_valid_i(init_valid_i), .init_addr_i(init_addr_i), .init_data_i(init_data_i),
    .init_ready_o(init_ready_o), .restart_i(restart_i),
    .core_we_i(core_we_i), .core_addr_i(core_addr_i), .core_data_i(core_data_i),
    .core_stall_o(core_stall_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .init_done_o(init_done_o), .init_err_o(init_err_o),
    .init_count_o(init_count_o)
  );

  init_stream_sink #(.DEPTH(1), .AW(1), .DW(DW)) dut1 (
    .clk(clk), .rst_ni(rst_ni),
    .init_valid_i(s_valid), .init_addr_i(s_addr), .init_data_i(s_data),
    .init_ready_o(s_ready), .restart_i(s_restart),
    .core_we_i(s_core_we), .core_addr_i(s_core_addr), .core_data_i(s_core_data),
    .core_stall_o(s_stall), .mem_we_o(s_we), .mem_addr_o(s_maddr),
    .mem_data_o(s_mdata), .init_done_o(s_done), .init_err_o(s_err),
    .init_count_o(s_count)
  );

  typedef struct {
    logic          restart;
    logic          vld;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          cwe;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cdata;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_done;
    logic          e_err;
    logic [AW:0]   e_cnt;
    logic          e_stall;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of init/core inputs, clock it, sample 1 time unit later.
  task automatic cyc(input logic rs, input logic v, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic cw,
                     input logic [AW-1:0] ca, input logic [DW-1:0] cd);
    restart_i    = rs;
    init_valid_i = v;
    init_addr_i  = a;
    init_data_i  = d;
    core_we_i    = cw;
    core_addr_i  = ca;
    core_data_i  = cd;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pat(input int a);
    return 40'h55_0000_0000 | DW'(a * 3);
  endfunction

  // Full clean pass 0..DEPTH-1 with a 3-cycle gap at 50 and a core write
  // during FILL (entry 7) and coincident with the final beat.
  task automatic clean_pass(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 50) begin
        for (int g = 0; g < 3; g++) begin
          cyc(1'b0, 1'b0, AW'(i), pat(i), 1'b0, 8'd0, 40'd0);
          chk({tag, "_gap_we"}, 64'(mem_we_o), 64'd0);
          chk({tag, "_gap_cnt"}, 64'(init_count_o), 64'd50);
          chk({tag, "_gap_err"}, 64'(init_err_o), 64'd0);
        end
      end
      cyc(1'b0, 1'b1, AW'(i), pat(i), (i == 7) || (i == DEPTH - 1),
          (i == 7) ? 8'd7 : 8'd9, 40'h99);
      chk({tag, "_we"}, 64'(mem_we_o), 64'd1);
      chk({tag, "_addr"}, 64'(mem_addr_o), 64'(i));
      chk({tag, "_data"}, 64'(mem_data_o), 64'(pat(i)));
      chk({tag, "_cnt"}, 64'(init_count_o), 64'(i + 1));
      chk({tag, "_done"}, 64'(init_done_o), 64'(i == DEPTH - 1));
      chk({tag, "_stall"}, 64'(core_stall_o), 64'(i != DEPTH - 1));
    end
    chk({tag, "_ready"}, 64'(init_ready_o), 64'd0);
    // The core write coincident with the last beat must not appear now.
    cyc(1'b0, 1'b1, 8'd3, 40'h1234, 1'b0, 8'd0, 40'd0);
    chk({tag, "_post_we"}, 64'(mem_we_o), 64'd0);
    chk({tag, "_post_cnt"}, 64'(init_count_o), 64'(DEPTH));
  endtask

  vec_t vecs[12];

  initial begin
    // restart vld addr data cwe caddr cdata | we addr data done err cnt stall
    vecs[0]  = '{1'b0, 1'b1, 8'd5, 40'h5,  1'b0, 8'd0, 40'h0,  1'b0, 8'd0, 40'h0,  1'b0, 1'b0, 9'd0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 8'd0, 40'h11, 1'b0, 8'd0, 40'h0,  1'b1, 8'd0, 40'h11, 1'b0, 1'b0, 9'd1, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 8'd1, 40'h22, 1'b1, 8'd7, 40'hAB, 1'b1, 8'd1, 40'h22, 1'b0, 1'b0, 9'd2, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 8'd2, 40'h0,  1'b1, 8'd7, 40'hAB, 1'b0, 8'd1, 40'h22, 1'b0, 1'b0, 9'd2, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 8'd2, 40'h33, 1'b0, 8'd0, 40'h0,  1'b1, 8'd2, 40'h33, 1'b0, 1'b0, 9'd3, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 8'd4, 40'h44, 1'b0, 8'd0, 40'h0,  1'b0, 8'd2, 40'h33, 1'b0, 1'b1, 9'd0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 8'd3, 40'h45, 1'b0, 8'd0, 40'h0,  1'b0, 8'd2, 40'h33, 1'b0, 1'b1, 9'd0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 8'd0, 40'h55, 1'b0, 8'd0, 40'h0,  1'b1, 8'd0, 40'h55, 1'b0, 1'b1, 9'd1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 8'd1, 40'h66, 1'b0, 8'd0, 40'h0,  1'b1, 8'd1, 40'h66, 1'b0, 1'b1, 9'd2, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 8'd0, 40'h77, 1'b0, 8'd0, 40'h0,  1'b1, 8'd0, 40'h77, 1'b0, 1'b1, 9'd1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 8'd1, 40'h88, 1'b0, 8'd0, 40'h0,  1'b0, 8'd0, 40'h77, 1'b0, 1'b0, 9'd0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 8'd1, 40'h99, 1'b0, 8'd0, 40'h0,  1'b0, 8'd0, 40'h77, 1'b0, 1'b0, 9'd0, 1'b1};

    rst_ni = 1'b0;
    restart_i = 1'b0; init_valid_i = 1'b0; init_addr_i = '0; init_data_i = '0;
    core_we_i = 1'b0; core_addr_i = '0; core_data_i = '0;
    s_valid = 1'b0; s_addr = 1'b0; s_data = '0; s_restart = 1'b0;
    s_core_we = 1'b0; s_core_addr = 1'b0; s_core_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 64'(mem_we_o), 64'd0);
    chk("rst_addr", 64'(mem_addr_o), 64'd0);
    chk("rst_data", 64'(mem_data_o), 64'd0);
    chk("rst_done", 64'(init_done_o), 64'd0);
    chk("rst_err", 64'(init_err_o), 64'd0);
    chk("rst_cnt", 64'(init_count_o), 64'd0);
    chk("rst_stall", 64'(core_stall_o), 64'd1);
    chk("rst_ready", 64'(init_ready_o), 64'd1);
    rst_ni = 1'b1;

    // Vector table: lock, gap, error, resync, restart.
    for (int k = 0; k < 12; k++) begin
      cyc(vecs[k].restart, vecs[k].vld, vecs[k].addr, vecs[k].data,
          vecs[k].cwe, vecs[k].caddr, vecs[k].cdata);
      chk($sformatf("v%0d_we", k), 64'(mem_we_o), 64'(vecs[k].e_we));
      chk($sformatf("v%0d_addr", k), 64'(mem_addr_o), 64'(vecs[k].e_addr));
      chk($sformatf("v%0d_data", k), 64'(mem_data_o), 64'(vecs[k].e_data));
      chk($sformatf("v%0d_done", k), 64'(init_done_o), 64'(vecs[k].e_done));
      chk($sformatf("v%0d_err", k), 64'(init_err_o), 64'(vecs[k].e_err));
      chk($sformatf("v%0d_cnt", k), 64'(init_count_o), 64'(vecs[k].e_cnt));
      chk($sformatf("v%0d_stall", k), 64'(core_stall_o), 64'(vecs[k].e_stall));
    end

    // Error on 51 -> 53 mid-pass, then back to waiting for 0.
    for (int i = 0; i < 52; i++) cyc(1'b0, 1'b1, AW'(i), pat(i), 1'b0, 8'd0, 40'd0);
    chk("skip_pre_cnt", 64'(init_count_o), 64'd52);
    cyc(1'b0, 1'b1, 8'd53, 40'hDEAD, 1'b0, 8'd0, 40'd0);
    chk("skip_we", 64'(mem_we_o), 64'd0);
    chk("skip_err", 64'(init_err_o), 64'd1);
    chk("skip_cnt", 64'(init_count_o), 64'd0);
    chk("skip_addr_hold", 64'(mem_addr_o), 64'd51);
    cyc(1'b1, 1'b0, 8'd0, 40'd0, 1'b0, 8'd0, 40'd0);
    chk("skip_restart_err", 64'(init_err_o), 64'd0);

    // Mid-stream lock: 100..255 ignored, then a clean pass.
    for (int i = 100; i < DEPTH; i++) begin
      cyc(1'b0, 1'b1, AW'(i), pat(i), 1'b0, 8'd0, 40'd0);
      chk("lock_we", 64'(mem_we_o), 64'd0);
    end
    clean_pass("pass1");

    // Core write after done.
    cyc(1'b0, 1'b0, 8'd0, 40'd0, 1'b1, 8'd7, 40'hAB);
    chk("core_we", 64'(mem_we_o), 64'd1);
    chk("core_addr", 64'(mem_addr_o), 64'd7);
    chk("core_data", 64'(mem_data_o), 64'hAB);
    cyc(1'b0, 1'b0, 8'd0, 40'd0, 1'b0, 8'd0, 40'd0);
    chk("core_idle_we", 64'(mem_we_o), 64'd0);
    chk("core_idle_data", 64'(mem_data_o), 64'hAB);

    // Restart in DONE (with a dropped core write) and a second pass.
    cyc(1'b1, 1'b0, 8'd0, 40'd0, 1'b1, 8'd8, 40'hCD);
    chk("rs_we", 64'(mem_we_o), 64'd0);
    chk("rs_done", 64'(init_done_o), 64'd0);
    chk("rs_err", 64'(init_err_o), 64'd0);
    chk("rs_stall", 64'(core_stall_o), 64'd1);
    chk("rs_cnt", 64'(init_count_o), 64'd0);
    clean_pass("pass2");

    // Async reset at beat 120 of a fresh pass.
    cyc(1'b1, 1'b0, 8'd0, 40'd0, 1'b0, 8'd0, 40'd0);
    for (int i = 0; i < 120; i++) cyc(1'b0, 1'b1, AW'(i), pat(i), 1'b0, 8'd0, 40'd0);
    chk("ar_pre_cnt", 64'(init_count_o), 64'd120);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("ar_we", 64'(mem_we_o), 64'd0);
    chk("ar_addr", 64'(mem_addr_o), 64'd0);
    chk("ar_data", 64'(mem_data_o), 64'd0);
    chk("ar_cnt", 64'(init_count_o), 64'd0);
    chk("ar_stall", 64'(core_stall_o), 64'd1);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    clean_pass("pass3");

    // DEPTH=1 instance.
    chk("d1_rst_done", 64'(s_done), 64'd0);
    chk("d1_rst_stall", 64'(s_stall), 64'd1);
    s_valid = 1'b1; s_addr = 1'b0; s_data = 40'h3C;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("d1_we", 64'(s_we), 64'd1);
    chk("d1_data", 64'(s_mdata), 64'h3C);
    chk("d1_done", 64'(s_done), 64'd1);
    chk("d1_cnt", 64'(s_count), 64'd1);
    chk("d1_stall", 64'(s_stall), 64'd0);
    chk("d1_err", 64'(s_err), 64'd0);
    chk("d1_ready", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("d1_we_off", 64'(s_we), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
